imem_loader: RTL

Byte-stream program loader that writes 16-bit words into the instruction memory, the write side of the port the CPU only reads. It sits beside the CPU on the instruction address/data path and holds the CPU in reset while it drives the memory. It parses a framed image of start address, word count, data words and checksum. It releases the CPU only after a valid checksum.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port: parses a framed
// image (address, count, words, checksum) and holds the CPU in reset until it verifies.
module imem_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rearm,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_st,
  output logic        mem_oe,
  output logic        cpu_hold,
  output logic        done,
  output logic [1:0]  err
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA_LO,
    S_DATA_HI, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_addr;
  logic [15:0]   r_data;
  logic [15:0]   r_cnt;
  logic [7:0]    r_sum;
  logic [IW-1:0] r_idle;
  logic [1:0]    r_err;
  logic          r_ready;
  logic          r_st;
  logic          r_done;
  logic          r_hold;

  logic          w_accept;
  logic          w_timed;
  logic          w_tmo;
  logic          w_sum_ok;
  logic [15:0]   w_cnt_hdr;

  function automatic logic rx_state(input state_t s);
    return (s == S_ADDR_LO) || (s == S_ADDR_HI) || (s == S_CNT_LO) ||
           (s == S_CNT_HI)  || (s == S_DATA_LO) || (s == S_DATA_HI) ||
           (s == S_CHECK);
  endfunction

  always_comb begin
    w_accept  = in_valid && r_ready;
    w_timed   = rx_state(r_state) && (r_state != S_ADDR_LO);
    w_tmo     = w_timed && !w_accept && (r_idle == IW'(TIMEOUT - 1));
    w_cnt_hdr = {in_data, r_cnt[7:0]};
    w_sum_ok  = (8'(r_sum + in_data) == 8'h00);
    w_next    = r_state;
    case (r_state)
      S_IDLE:    w_next = S_ADDR_LO;
      S_ADDR_LO: if (w_accept) w_next = S_ADDR_HI;
      S_ADDR_HI: if (w_accept) w_next = S_CNT_LO;
      S_CNT_LO:  if (w_accept) w_next = S_CNT_HI;
      S_CNT_HI:  if (w_accept) w_next = (w_cnt_hdr != 16'd0) ? S_DATA_LO : S_CHECK;
      S_DATA_LO: if (w_accept) w_next = S_DATA_HI;
      S_DATA_HI: if (w_accept) w_next = S_WRITE;
      S_WRITE:   w_next = (r_cnt != 16'd1) ? S_DATA_LO : S_CHECK;
      S_CHECK:   if (w_accept) w_next = w_sum_ok ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:   if (rearm) w_next = S_ADDR_LO;
      default:   w_next = S_IDLE;
    endcase
    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (w_tmo) w_next = S_ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_cnt   <= 16'h0000;
      r_sum   <= 8'h00;
      r_idle  <= '0;
      r_err   <= 2'b00;
      r_ready <= 1'b0;
      r_st    <= 1'b0;
      r_done  <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      // Outputs are registered from the next state so they line up with r_state.
      r_state <= w_next;
      r_ready <= rx_state(w_next);
      r_st    <= (w_next == S_WRITE);
      r_done  <= (w_next == S_DONE);
      r_hold  <= (w_next != S_DONE);

      if (w_accept || (w_next != r_state)) r_idle <= '0;
      else if (w_timed)                    r_idle <= r_idle + 1'b1;

      if ((w_next == S_ADDR_LO) && (r_state != S_ADDR_LO)) r_sum <= 8'h00;
      else if (w_accept)                                    r_sum <= r_sum + in_data;

      case (r_state)
        S_ADDR_LO: if (w_accept) r_addr[7:0]  <= in_data;
        S_ADDR_HI: if (w_accept) r_addr[15:8] <= in_data;
        S_CNT_LO:  if (w_accept) r_cnt[7:0]   <= in_data;
        S_CNT_HI:  if (w_accept) r_cnt[15:8]  <= in_data;
        S_DATA_LO: if (w_accept) r_data[7:0]  <= in_data;
        S_DATA_HI: if (w_accept) r_data[15:8] <= in_data;
        S_WRITE: begin
          r_addr <= r_addr + 16'd1;
          r_cnt  <= r_cnt - 16'd1;
        end
        S_CHECK:   if (w_accept && !w_sum_ok) r_err <= 2'b01;
        S_DONE,
        S_ERROR:   if (rearm) r_err <= 2'b00;
        default: ;
      endcase
      if (w_tmo) r_err <= 2'b10;
    end
  end

  assign in_ready = r_ready;
  assign mem_addr = r_addr;
  assign mem_data = r_data;
  assign mem_st   = r_st;
  assign mem_oe   = 1'b0;
  assign cpu_hold = r_hold;
  assign done     = r_done;
  assign err      = r_err;

endmodule
